uart_ctrl: RTL and testbench

Memory-mapped UART controller sitting at the far end of the MMU's UART port. It is the responder for the MMU's data path. It consumes the data-register access stream (`uartOp_i`, `uart_storeData_i`), which the MMU raises for address 0xBFD003F8. It returns `uart_load_data_o` for loads, and drives the `dataReady`/`writeReady` status bits that the MMU presents at 0xBFD003FC. Serial line format is 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.

---
 rtl/uart_ctrl_if.sv | 22 ++
 rtl/uart_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if -- MMU <-> UART data-register bus.
//   master (MMU side) drives : uartOp_i, uart_storeData_i, stall_i
//   slave  (UART side) drives: uart_load_data_o, dataReady, writeReady
// The signal names match the MMU's port names so both ends connect by name.
interface uart_ctrl_if;
  logic [3:0]  uartOp_i;
  logic [31:0] uart_storeData_i;
  logic        stall_i;
  logic [31:0] uart_load_data_o;
  logic        dataReady;
  logic        writeReady;

  modport master (
    output uartOp_i, uart_storeData_i, stall_i,
    input  uart_load_data_o, dataReady, writeReady
  );

  modport slave (
    input  uartOp_i, uart_storeData_i, stall_i,
    output uart_load_data_o, dataReady, writeReady
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl -- memory-mapped 8N1 UART responder for the MMU's UART port.
// Ports:
//   clk  : core clock (only clock of the block)
//   rst  : asynchronous active-low reset
//   bus  : uart_ctrl_if.slave -- op code, store data, stall in;
//          load data, dataReady, writeReady out
//   rxd  : serial input, asynchronous to clk
//   txd  : serial output, idle high
// Parameters: CLK_FREQ / BAUD give DIV clocks per bit (DIV >= 4).
module uart_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  uart_ctrl_if.slave  bus,
  input  logic        rxd,
  output logic        txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Access decode: a stalled cycle never commits.
  logic w_load;
  logic w_store;
  assign w_load  = !bus.stall_i && (bus.uartOp_i inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW});
  assign w_store = !bus.stall_i && (bus.uartOp_i inside {MEM_SB, MEM_SH, MEM_SW});

  // Only the low byte of a store reaches the line.
  logic w_unused_store;
  assign w_unused_store = ^bus.uart_storeData_i[31:8];

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_txd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_store) begin
            r_tx_shift <= bus.uart_storeData_i[7:0];
            r_tx_cnt   <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              // txd is registered, so load the next bit while shifting.
              r_tx_idx   <= r_tx_idx + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd            = r_txd;
  assign bus.writeReady = (r_tx_state == TX_IDLE);

  // ---------------- receiver ----------------
  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  logic r_rx_s1;
  logic r_rx_s2;
  logic r_rx_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_byte;
  logic          r_data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_shift   <= '0;
      r_rx_byte    <= '0;
      r_data_ready <= 1'b0;
    end else begin
      // A load clears the flag; a byte completing in the same cycle sets it
      // again below, so the set wins.
      if (w_load) r_data_ready <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_END) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_idx   <= r_rx_idx + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_END) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
            // A low stop bit is a framing error: the byte is discarded.
            if (r_rx_s2) begin
              r_rx_byte    <= r_rx_shift;
              r_data_ready <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.uart_load_data_o = {24'b0, r_rx_byte};
  assign bus.dataReady        = r_data_ready;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl -- self-checking bench for uart_ctrl at DIV = 16.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_uart_ctrl;

  localparam int DIV = 16;
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  uart_ctrl_if u_if();

  uart_ctrl #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if),
    .rxd (rxd),
    .txd (txd)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] op;
    logic       stall;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Level of bit k (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Call right after the commit edge: checks txd and writeReady every cycle.
  task automatic tx_frame_check(input logic [7:0] b, input string tag);
    for (int t = 0; t < 10 * DIV; t++) begin
      check($sformatf("%s_txd_t%0d", tag, t), {31'b0, txd}, {31'b0, frame_bit(b, t / DIV)});
      check($sformatf("%s_busy_t%0d", tag, t), {31'b0, u_if.writeReady}, 32'd0);
      tick();
    end
    check($sformatf("%s_ready_end", tag), {31'b0, u_if.writeReady}, 32'd1);
    $display("tx frame 0x%02h checked (%s)", b, tag);
  endtask

  // Call right after an edge: drives one frame on rxd, stop bit as given.
  task automatic rx_send(input logic [7:0] b, input logic stop_lvl);
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 9) ? stop_lvl : frame_bit(b, k);
      repeat (DIV) tick();
    end
    rxd = 1'b1;
    $display("rx frame 0x%02h sent, stop=%0b", b, stop_lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!u_if.writeReady && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, {31'b0, u_if.writeReady}, 32'd1);
  endtask

  task automatic commit(input logic [3:0] op, input logic [31:0] data);
    u_if.uartOp_i         = op;
    u_if.uart_storeData_i = data;
    u_if.stall_i          = 1'b0;
    tick();
    u_if.uartOp_i = MEM_NOP;
  endtask

  logic [7:0] model_byte;
  logic       model_dr;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    u_if.uartOp_i         = MEM_NOP;
    u_if.uart_storeData_i = '0;
    u_if.stall_i          = 1'b0;

    // Reset
    rst = 1'b0;
    repeat (3) tick();
    check("rst_hold_txd", {31'b0, txd}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_wr", {31'b0, u_if.writeReady}, 32'd1);
    check("rst_dr", {31'b0, u_if.dataReady}, 32'd0);
    check("rst_data", u_if.uart_load_data_o, 32'd0);
    $display("reset released");

    // Op-code decode table
    vecs[0]  = '{MEM_NOP, 1'b0, 1'b0}; vecs[1]  = '{MEM_NOP, 1'b1, 1'b0};
    vecs[2]  = '{MEM_LB,  1'b0, 1'b0}; vecs[3]  = '{MEM_LB,  1'b1, 1'b0};
    vecs[4]  = '{MEM_LBU, 1'b0, 1'b0}; vecs[5]  = '{MEM_LBU, 1'b1, 1'b0};
    vecs[6]  = '{MEM_LH,  1'b0, 1'b0}; vecs[7]  = '{MEM_LHU, 1'b0, 1'b0};
    vecs[8]  = '{MEM_LW,  1'b0, 1'b0}; vecs[9]  = '{MEM_LW,  1'b1, 1'b0};
    vecs[10] = '{MEM_SB,  1'b1, 1'b0}; vecs[11] = '{MEM_SB,  1'b0, 1'b1};
    vecs[12] = '{MEM_SH,  1'b1, 1'b0}; vecs[13] = '{MEM_SH,  1'b0, 1'b1};
    vecs[14] = '{MEM_SW,  1'b1, 1'b0}; vecs[15] = '{MEM_SW,  1'b0, 1'b1};
    vecs[16] = '{4'd9,    1'b0, 1'b0}; vecs[17] = '{4'd15,   1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      u_if.uartOp_i         = vecs[i].op;
      u_if.stall_i          = vecs[i].stall;
      u_if.uart_storeData_i = 32'h0000_005A;
      tick();
      u_if.uartOp_i = MEM_NOP;
      u_if.stall_i  = 1'b0;
      check($sformatf("vec%0d_wr", i), {31'b0, u_if.writeReady}, {31'b0, !vecs[i].exp_busy});
      check($sformatf("vec%0d_txd", i), {31'b0, txd}, {31'b0, !vecs[i].exp_busy});
      $display("vector %0d op=%0d stall=%0b", i, vecs[i].op, vecs[i].stall);
      if (vecs[i].exp_busy) wait_idle($sformatf("vec%0d", i));
    end

    // TX frame 0xA5
    commit(MEM_SB, 32'h0000_00A5);
    tx_frame_check(8'hA5, "txA5");

    // Stall then busy drop
    u_if.uartOp_i         = MEM_SW;
    u_if.uart_storeData_i = 32'h0000_0041;
    u_if.stall_i          = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_wr", i), {31'b0, u_if.writeReady}, 32'd1);
    end
    u_if.stall_i = 1'b0;
    tick();
    u_if.uartOp_i = MEM_NOP;
    fork
      tx_frame_check(8'h41, "tx41");
      begin
        repeat (19) tick();
        commit(MEM_SB, 32'h0000_0042);
      end
    join
    for (int i = 0; i < 40; i++) begin
      check($sformatf("after41_txd%0d", i), {31'b0, txd}, 32'd1);
      tick();
    end

    // RX good byte with exact flag latency
    fork
      rx_send(8'h3C, 1'b1);
      begin
        repeat (154) tick();
        check("rx3C_dr_early", {31'b0, u_if.dataReady}, 32'd0);
        tick();
        check("rx3C_dr", {31'b0, u_if.dataReady}, 32'd1);
        check("rx3C_data", u_if.uart_load_data_o, 32'h3C);
      end
    join
    repeat (4) tick();
    u_if.uartOp_i = MEM_LBU;
    #1;
    check("load3C_during", u_if.uart_load_data_o, 32'h3C);
    tick();
    u_if.uartOp_i = MEM_NOP;
    check("load3C_dr", {31'b0, u_if.dataReady}, 32'd0);
    check("load3C_keep", u_if.uart_load_data_o, 32'h3C);

    // Framing error
    rx_send(8'h55, 1'b0);
    repeat (4) tick();
    check("frame_err_dr", {31'b0, u_if.dataReady}, 32'd0);
    check("frame_err_data", u_if.uart_load_data_o, 32'h3C);

    // Start-bit glitch
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (200) tick();
    check("glitch_dr", {31'b0, u_if.dataReady}, 32'd0);
    check("glitch_data", u_if.uart_load_data_o, 32'h3C);

    // Overrun
    rx_send(8'h11, 1'b1);
    repeat (4) tick();
    rx_send(8'h22, 1'b1);
    repeat (4) tick();
    check("overrun_dr", {31'b0, u_if.dataReady}, 32'd1);
    check("overrun_data", u_if.uart_load_data_o, 32'h22);

    // Load commit in the completion cycle: set wins
    fork
      rx_send(8'h7E, 1'b1);
      begin
        repeat (154) tick();
        commit(MEM_LBU, 32'h0);
        check("race_dr", {31'b0, u_if.dataReady}, 32'd1);
        check("race_data", u_if.uart_load_data_o, 32'h7E);
      end
    join
    commit(MEM_LW, 32'h0);
    check("race_clear_dr", {31'b0, u_if.dataReady}, 32'd0);

    // Full duplex
    commit(MEM_SB, 32'h0000_00FF);
    fork
      tx_frame_check(8'hFF, "txFF");
      rx_send(8'h00, 1'b1);
    join
    repeat (4) tick();
    check("duplex_dr", {31'b0, u_if.dataReady}, 32'd1);
    check("duplex_data", u_if.uart_load_data_o, 32'h00);

    // Randomized full-duplex traffic against the reference model
    model_byte = 8'h00;
    model_dr   = 1'b1;
    for (int it = 0; it < 8; it++) begin
      logic [7:0] tb_byte;
      logic [7:0] rb_byte;
      logic       stop_lvl;
      int         dly;
      int         nstall;
      tb_byte  = 8'($urandom);
      rb_byte  = 8'($urandom);
      stop_lvl = ($urandom_range(0, 3) != 0);
      dly      = $urandom_range(0, 10);
      nstall   = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        commit(MEM_LB, 32'h0);
        model_dr = 1'b0;
      end
      u_if.uartOp_i         = MEM_SH;
      u_if.uart_storeData_i = {24'($urandom), tb_byte};
      u_if.stall_i          = 1'b1;
      for (int s = 0; s < nstall; s++) begin
        tick();
        check($sformatf("rnd%0d_stall%0d_wr", it, s), {31'b0, u_if.writeReady}, 32'd1);
      end
      u_if.stall_i = 1'b0;
      tick();
      u_if.uartOp_i = MEM_NOP;
      fork
        tx_frame_check(tb_byte, $sformatf("rnd%0d", it));
        begin
          repeat (dly) tick();
          rx_send(rb_byte, stop_lvl);
        end
      join
      if (stop_lvl) begin
        model_byte = rb_byte;
        model_dr   = 1'b1;
      end
      repeat (4) tick();
      check($sformatf("rnd%0d_dr", it), {31'b0, u_if.dataReady}, {31'b0, model_dr});
      check($sformatf("rnd%0d_data", it), u_if.uart_load_data_o, {24'b0, model_byte});
    end

    // Asynchronous reset mid-frame
    commit(MEM_SB, 32'h0000_0000);
    repeat (20) tick();
    check("midtx_txd_before", {31'b0, txd}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("midtx_txd_async", {31'b0, txd}, 32'd1);
    check("midtx_wr_async", {31'b0, u_if.writeReady}, 32'd1);
    check("midtx_dr_async", {31'b0, u_if.dataReady}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("midtx_txd_after", {31'b0, txd}, 32'd1);
    check("midtx_wr_after", {31'b0, u_if.writeReady}, 32'd1);
    check("midtx_data_after", u_if.uart_load_data_o, 32'd0);
    $display("mid-frame reset done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
